// File: rtl/dispatch_stage_pkg.sv
// dispatch_stage_pkg: shared types and default sizes for the rename/dispatch stage
package dispatch_stage_pkg;

    localparam int DEFAULT_TAG_W = 6;
    localparam int DEFAULT_NUM_Q = 4;

    typedef struct packed {
        logic                     pend;
        logic [DEFAULT_TAG_W-1:0] tag;
    } rst_entry_t;

    typedef enum logic {RUN, BR_WAIT} dispatch_state_e;

endpackage

// File: rtl/dispatch_stage_tag_freelist.sv
// tag_freelist: circular free list of rename tags with sticky over-return error
// DISPATCH_CDB_BYPASS_EN: a tag returned while the list is empty is allocatable that same cycle
module tag_freelist #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic             ret,
    input  logic [TAG_W-1:0] ret_tag,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             avail,
    output logic             tag_err
);
    localparam int DEPTH = 1 << TAG_W;

    logic [TAG_W-1:0] tags [DEPTH];
    logic [TAG_W-1:0] rd_ptr, wr_ptr;
    logic [TAG_W:0]   count;
    logic             full, empty, ret_ok;

    assign full   = count == (TAG_W+1)'(DEPTH);
    assign empty  = count == '0;
    assign ret_ok = ret & ~full;
`ifdef DISPATCH_CDB_BYPASS_EN
    // empty implies rd_ptr == wr_ptr, so the returning tag is the head
    assign avail     = ~empty | ret;
    assign alloc_tag = empty ? ret_tag : tags[rd_ptr];
`else
    assign avail     = ~empty;
    assign alloc_tag = tags[rd_ptr];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) tags[i] <= TAG_W'(i);
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= (TAG_W+1)'(DEPTH);
            tag_err <= 1'b0;
        end else begin
            if (ret_ok) tags[wr_ptr] <= ret_tag;
            rd_ptr <= rd_ptr + TAG_W'(alloc);
            wr_ptr <= wr_ptr + TAG_W'(ret_ok);
            count  <= count + (TAG_W+1)'(ret_ok) - (TAG_W+1)'(alloc);
            if (ret && full) tag_err <= 1'b1;
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// dispatch_stage: rename tag allocation, queue steering and branch stall between IFQ and issue queues
// DISPATCH_CDB_BYPASS_EN: same-cycle CDB wakeup of sources and free-list refill
module dispatch_stage
    import dispatch_stage_pkg::*;
#(
    parameter int TAG_W     = DEFAULT_TAG_W,
    parameter int ARCH_REGS = 32,
    parameter int NUM_Q     = DEFAULT_NUM_Q,
    parameter int AREG_W    = $clog2(ARCH_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [AREG_W-1:0] if_rs1,
    input  logic [AREG_W-1:0] if_rs2,
    input  logic [AREG_W-1:0] if_rd,
    input  logic              if_rd_wr,
    input  logic [NUM_Q-1:0]  if_qsel,
    input  logic              if_branch,
    input  logic [NUM_Q-1:0]  q_ready,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic              cdb_branch,
    input  logic              cdb_branch_taken,
    output logic [NUM_Q-1:0]  disp_valid,
    output logic [TAG_W-1:0]  disp_rs1_tag,
    output logic [TAG_W-1:0]  disp_rs2_tag,
    output logic [TAG_W-1:0]  disp_rd_tag,
    output logic              disp_rs1_rdy,
    output logic              disp_rs2_rdy,
    output logic              redirect,
    output logic              tag_err
);
    dispatch_state_e      state, state_nxt;
    logic [ARCH_REGS-1:0] pend;
    logic [TAG_W-1:0]     tag_tab [ARCH_REGS];
    logic [TAG_W-1:0]     alloc_tag;
    logic                 avail, accept, alloc, cdb_resolve, rs1_rdy, rs2_rdy;

    assign if_ready    = (state == RUN) & |(if_qsel & q_ready) & (~if_rd_wr | avail);
    assign accept      = if_valid & if_ready;
    assign alloc       = accept & if_rd_wr & (if_rd != '0);
    assign cdb_resolve = cdb_valid & cdb_branch;
`ifdef DISPATCH_CDB_BYPASS_EN
    assign rs1_rdy = ~pend[if_rs1] | (cdb_valid & (tag_tab[if_rs1] == cdb_tag));
    assign rs2_rdy = ~pend[if_rs2] | (cdb_valid & (tag_tab[if_rs2] == cdb_tag));
`else
    assign rs1_rdy = ~pend[if_rs1];
    assign rs2_rdy = ~pend[if_rs2];
`endif

    tag_freelist #(.TAG_W(TAG_W)) u_freelist (
        .clk      (clk),
        .rst      (rst),
        .alloc    (alloc),
        .ret      (cdb_valid),
        .ret_tag  (cdb_tag),
        .alloc_tag(alloc_tag),
        .avail    (avail),
        .tag_err  (tag_err)
    );

    always_comb begin
        state_nxt = state;
        if (state == RUN && accept && if_branch) state_nxt = BR_WAIT;
        else if (state == BR_WAIT && cdb_resolve) state_nxt = RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            disp_valid   <= '0;
            disp_rs1_tag <= '0;
            disp_rs2_tag <= '0;
            disp_rd_tag  <= '0;
            disp_rs1_rdy <= 1'b0;
            disp_rs2_rdy <= 1'b0;
            redirect     <= 1'b0;
        end else begin
            state      <= state_nxt;
            disp_valid <= accept ? if_qsel : '0;
            redirect   <= (state == BR_WAIT) & cdb_resolve & cdb_branch_taken;
            if (accept) begin
                disp_rs1_tag <= tag_tab[if_rs1];
                disp_rs2_tag <= tag_tab[if_rs2];
                disp_rd_tag  <= alloc ? alloc_tag : '0;
                disp_rs1_rdy <= rs1_rdy;
                disp_rs2_rdy <= rs2_rdy;
            end
        end
    end

    // entry 0 is never written, so x0 always reads as ready with tag 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
            for (int i = 0; i < ARCH_REGS; i++) tag_tab[i] <= '0;
        end else begin
            for (int i = 1; i < ARCH_REGS; i++) begin
                if (alloc && if_rd == AREG_W'(i)) begin
                    pend[i]    <= 1'b1;
                    tag_tab[i] <= alloc_tag;
                end else if (cdb_valid && pend[i] && tag_tab[i] == cdb_tag) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed and random checks of dispatch_stage against a queue-based rename model
module tb_dispatch_stage;
    localparam int TAG_W = 6, ARCH_REGS = 32, NUM_Q = 4, AREG_W = 5, DEPTH = 64;

    logic clk = 1'b0, rst = 1'b1;
    logic if_valid, if_rd_wr, if_branch, cdb_valid, cdb_branch, cdb_branch_taken;
    logic [AREG_W-1:0] if_rs1, if_rs2, if_rd;
    logic [NUM_Q-1:0]  if_qsel, q_ready, disp_valid;
    logic [TAG_W-1:0]  cdb_tag, disp_rs1_tag, disp_rs2_tag, disp_rd_tag;
    logic if_ready, disp_rs1_rdy, disp_rs2_rdy, redirect, tag_err;

    int n_cmp = 0, n_bad = 0;

    int fl[$];
    bit m_pend[ARCH_REGS];
    int m_tag[ARCH_REGS];
    bit m_brwait, m_err, m_ready, m_acc;
    int e_valid, e_rs1_tag, e_rs2_tag, e_rd_tag, e_rs1_rdy, e_rs2_rdy, e_redirect;

    dispatch_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_rs1(if_rs1), .if_rs2(if_rs2), .if_rd(if_rd), .if_rd_wr(if_rd_wr),
        .if_qsel(if_qsel), .if_branch(if_branch), .q_ready(q_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_branch(cdb_branch),
        .cdb_branch_taken(cdb_branch_taken), .disp_valid(disp_valid),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag), .disp_rd_tag(disp_rd_tag),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .redirect(redirect), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        for (int i = 0; i < DEPTH; i++) fl.push_back(i);
        for (int i = 0; i < ARCH_REGS; i++) begin
            m_pend[i] = 1'b0;
            m_tag[i]  = 0;
        end
        m_brwait = 1'b0; m_err = 1'b0;
        e_valid = 0; e_rs1_tag = 0; e_rs2_tag = 0; e_rd_tag = 0;
        e_rs1_rdy = 0; e_rs2_rdy = 0; e_redirect = 0;
    endtask

    task automatic idle();
        if_valid = 1'b0; if_rs1 = '0; if_rs2 = '0; if_rd = '0; if_rd_wr = 1'b0;
        if_qsel = 4'b0001; if_branch = 1'b0; q_ready = 4'b1111;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0;
    endtask

    task automatic instr(input int rs1, input int rs2, input int rd, input bit wr,
                         input logic [NUM_Q-1:0] q, input bit br);
        if_valid = 1'b1; if_rs1 = AREG_W'(rs1); if_rs2 = AREG_W'(rs2); if_rd = AREG_W'(rd);
        if_rd_wr = wr; if_qsel = q; if_branch = br;
    endtask

    task automatic cdb(input int t, input bit br, input bit taken);
        cdb_valid = 1'b1; cdb_tag = TAG_W'(t); cdb_branch = br; cdb_branch_taken = taken;
    endtask

    function automatic bit src_rdy(input int r);
`ifdef DISPATCH_CDB_BYPASS_EN
        return !m_pend[r] || (cdb_valid && m_tag[r] == int'(cdb_tag));
`else
        return !m_pend[r];
`endif
    endfunction

    // a random tag currently handed out (not sitting in the free list), or -1
    function automatic int out_tag();
        bit used[DEPTH];
        int c[$];
        for (int t = 0; t < DEPTH; t++) used[t] = 1'b0;
        foreach (fl[k]) used[fl[k]] = 1'b1;
        for (int t = 0; t < DEPTH; t++) if (!used[t]) c.push_back(t);
        return (c.size() == 0) ? -1 : c[$urandom_range(c.size() - 1)];
    endfunction

    // one clock: entered at negedge with inputs driven, returns at the next negedge
    task automatic cyc();
        int cnt, new_tag;
        bit avail, alloc;
        #1;
        cnt   = fl.size();
        avail = cnt != 0;
`ifdef DISPATCH_CDB_BYPASS_EN
        avail = avail || cdb_valid;
`endif
        m_ready = !m_brwait && ((if_qsel & q_ready) != 0) && (!if_rd_wr || avail);
        chk("if_ready", 32'(if_ready), 32'(m_ready));
        m_acc      = if_valid && m_ready;
        alloc      = m_acc && if_rd_wr && (if_rd != 0);
        e_redirect = int'(m_brwait && cdb_valid && cdb_branch && cdb_branch_taken);
        e_valid    = m_acc ? int'(if_qsel) : 0;
        if (cdb_valid) begin
            if (cnt == DEPTH) m_err = 1'b1;
            else fl.push_back(int'(cdb_tag));
        end
        new_tag = alloc ? fl.pop_front() : 0;
        if (m_acc) begin
            e_rs1_tag = m_tag[if_rs1]; e_rs2_tag = m_tag[if_rs2]; e_rd_tag = new_tag;
            e_rs1_rdy = int'(src_rdy(int'(if_rs1))); e_rs2_rdy = int'(src_rdy(int'(if_rs2)));
        end
        for (int i = 0; i < ARCH_REGS; i++)
            if (cdb_valid && m_pend[i] && m_tag[i] == int'(cdb_tag)) m_pend[i] = 1'b0;
        if (alloc) begin
            m_pend[if_rd] = 1'b1;
            m_tag[if_rd]  = new_tag;
        end
        if (!m_brwait && m_acc && if_branch) m_brwait = 1'b1;
        else if (m_brwait && cdb_valid && cdb_branch) m_brwait = 1'b0;
        @(posedge clk);
        #1;
        chk("disp_valid", 32'(disp_valid), e_valid);
        chk("rs1_tag", 32'(disp_rs1_tag), e_rs1_tag);
        chk("rs2_tag", 32'(disp_rs2_tag), e_rs2_tag);
        chk("rd_tag", 32'(disp_rd_tag), e_rd_tag);
        chk("rs1_rdy", 32'(disp_rs1_rdy), e_rs1_rdy);
        chk("rs2_rdy", 32'(disp_rs2_rdy), e_rs2_rdy);
        chk("redirect", 32'(redirect), e_redirect);
        chk("tag_err", 32'(tag_err), 32'(m_err));
        @(negedge clk);
    endtask

    initial begin
        int t;
        idle();
        model_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_disp_valid", 32'(disp_valid), 0);
        chk("rst_rs1_tag", 32'(disp_rs1_tag), 0);
        chk("rst_rs2_tag", 32'(disp_rs2_tag), 0);
        chk("rst_rd_tag", 32'(disp_rd_tag), 0);
        chk("rst_rs1_rdy", 32'(disp_rs1_rdy), 0);
        chk("rst_rs2_rdy", 32'(disp_rs2_rdy), 0);
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_tag_err", 32'(tag_err), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 1; i <= 4; i++) begin
            idle(); instr(0, 0, i, 1'b1, 4'b0001, 1'b0); cyc();
            chk("first_rd_tag", 32'(disp_rd_tag), i - 1);
            chk("first_disp_valid", 32'(disp_valid), 1);
        end

        idle(); instr(1, 2, 0, 1'b0, 4'b0001, 1'b0); cyc();
        chk("x1_tag", 32'(disp_rs1_tag), 0);
        chk("x1_pending", 32'(disp_rs1_rdy), 0);
        idle(); instr(1, 0, 0, 1'b0, 4'b0001, 1'b0); cdb(0, 1'b0, 1'b0);
`ifndef DISPATCH_CDB_BYPASS_EN
        if_valid = 1'b0; cyc();
        idle(); instr(1, 0, 0, 1'b0, 4'b0001, 1'b0);
`endif
        cyc();
        chk("x1_ready_after_cdb", 32'(disp_rs1_rdy), 1);

        for (int k = 0; k < 80 && fl.size() != 0; k++) begin
            idle();
            instr($urandom_range(31), $urandom_range(31), $urandom_range(31, 1), 1'b1, 4'b0001, 1'b0);
            cyc();
        end
        idle(); instr(3, 4, 7, 1'b1, 4'b0001, 1'b0); cyc();
        chk("stall_on_empty", 32'(if_ready), 0);
        cdb(5, 1'b0, 1'b0); cyc();
        cdb_valid = 1'b0;
        for (int k = 0; k < 3 && !m_acc; k++) cyc();
        chk("refill_dispatch", 32'(disp_valid), 1);
        chk("refill_tag", 32'(disp_rd_tag), 5);

        idle(); instr(0, 0, 0, 1'b0, 4'b0001, 1'b1); cyc();
        idle(); instr(1, 2, 0, 1'b0, 4'b0001, 1'b0);
        repeat (3) cyc();
        chk("branch_stall", 32'(if_ready), 0);
        cdb(out_tag(), 1'b1, 1'b1); cyc();
        chk("redirect_pulse", 32'(redirect), 1);
        cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0; cyc();
        chk("redirect_one_cycle", 32'(redirect), 0);
        chk("resume_dispatch", 32'(disp_valid), 1);

        idle(); instr(1, 2, 0, 1'b0, 4'b0010, 1'b0); q_ready = 4'b1101; cyc();
        chk("qsel_blocked", 32'(disp_valid), 0);
        q_ready = 4'b1111; cyc();
        chk("qsel_dispatch", 32'(disp_valid), 2);

        for (int k = 0; k < 400; k++) begin
            idle();
            if_valid  = $urandom_range(3) != 0;
            if_rs1    = AREG_W'($urandom); if_rs2 = AREG_W'($urandom); if_rd = AREG_W'($urandom);
            if_rd_wr  = $urandom_range(3) != 0;
            if_qsel   = NUM_Q'(1 << $urandom_range(NUM_Q - 1));
            q_ready   = NUM_Q'($urandom);
            if_branch = $urandom_range(7) == 0;
            t = out_tag();
            if ($urandom_range(1) == 1 && t >= 0)
                cdb(t, $urandom_range(1) == 1, $urandom_range(1) == 1);
            cyc();
        end

        for (int k = 0; k < 80 && fl.size() < DEPTH; k++) begin
            idle(); cdb(out_tag(), 1'b0, 1'b0); cyc();
        end
        idle(); cdb(9, 1'b0, 1'b0); cyc();
        chk("tag_err_set", 32'(tag_err), 1);
        for (int k = 0; k < DEPTH; k++) begin
            idle(); instr(0, 0, $urandom_range(31, 1), 1'b1, 4'b0001, 1'b0); cyc();
        end
        idle(); instr(0, 0, 6, 1'b1, 4'b0001, 1'b0); cyc();
        chk("count_held_at_64", 32'(if_ready), 0);

        idle(); cdb(out_tag(), 1'b0, 1'b0); cyc();
        idle(); instr(0, 0, 0, 1'b0, 4'b0001, 1'b1); cyc();
        idle(); instr(1, 0, 3, 1'b1, 4'b0001, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("midstall_rst_tag_err", 32'(tag_err), 0);
        chk("midstall_rst_valid", 32'(disp_valid), 0);
        chk("midstall_rst_redirect", 32'(redirect), 0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("post_rst_dispatch", 32'(disp_valid), 1);
        chk("post_rst_rd_tag", 32'(disp_rd_tag), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
